// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite bus package: transfer encodings and the byte-lane mask helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents:
//   transfer_size / transfer_kind / transfer_response / transfer_burst / transfer_protection
//   lane_mask(size, addr[1:0]) -> 4-bit byte-lane enable, also used by the bus controller
package ahb_sram_slave_pkg;

  typedef enum logic [2:0] {
    SIZE_BYTE   = 3'd0,
    SIZE_HALF   = 3'd1,
    SIZE_WORD   = 3'd2,
    SIZE_DWORD  = 3'd3,
    SIZE_4WORD  = 3'd4,
    SIZE_8WORD  = 3'd5,
    SIZE_16WORD = 3'd6,
    SIZE_32WORD = 3'd7
  } transfer_size;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } transfer_kind;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } transfer_response;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } transfer_burst;

  typedef logic [3:0] transfer_protection;

  // Byte-lane enables for a 32-bit data bus. Misaligned halfwords are rejected
  // elsewhere, so only the aligned shifts matter in practice.
  function automatic logic [3:0] lane_mask(input transfer_size i_size, input logic [1:0] i_addr);
    case (i_size)
      SIZE_BYTE: lane_mask = 4'b0001 << i_addr;
      SIZE_HALF: lane_mask = 4'b0011 << i_addr;
      default:   lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_slave_sram_byte_array.sv
// Word-organised SRAM with byte-enable writes and a registered read port; no reset.
// Latency: read data appears the cycle after i_re; writes land on the same edge.
// Backpressure: none, one read and one write may occur on every edge.
// Ports:
//   i_clk            clock
//   i_re, i_raddr    read enable / word address; o_rdata holds until the next i_re
//   i_we, i_waddr    write enable / word address
//   i_be, i_wdata    byte-lane enables / write data
// A read and write to the same word on one edge returns the old contents.
module sram_byte_array #(
  parameter int WORDS = 512,
  parameter int AW    = 9
) (
  input  logic          i_clk,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [3:0]    i_be,
  input  logic [31:0]   i_wdata
);

  logic [31:0] r_mem [WORDS];

  always_ff @(posedge i_clk) begin
    if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) begin
          r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite subordinate backing one device slot with a word-organised SRAM.
// Latency: OKAY data phase completes WAIT_STATES+1 cycles after the address edge; ERROR takes 2 cycles.
// Backpressure: ready_out low during wait states and the first ERROR cycle.
// Ports:
//   clock, reset (async, active-high)
//   sel/write/addr/size/burst/prot/trans/mastlock/ready : address phase from the bus
//   wdata : write data (data phase)
//   rdata/ready_out/resp : data phase response
// Optional build macro SRAM_RO_REGION_EN: writes below RO_BYTES get an ERROR response.
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0800,
  parameter int          MEM_BYTES   = 2048,
  parameter int          WAIT_STATES = 0,
  parameter int          RO_BYTES    = 256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sel,
  input  logic               write,
  input  logic [31:0]        addr,
  input  transfer_size       size,
  input  transfer_burst      burst,
  input  transfer_protection prot,
  input  transfer_kind       trans,
  input  logic               mastlock,
  input  logic               ready,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready_out,
  output transfer_response   resp
);

  localparam int AW    = $clog2(MEM_BYTES);
  localparam int WAW   = (AW > 2) ? AW - 2 : 1;
  localparam int WORDS = MEM_BYTES / 4;
  localparam logic [3:0] LP_WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  logic [1:0]     r_state;
  logic [3:0]     r_cnt;
  logic           r_pend;      // good data phase outstanding
  logic           r_wr;        // ... and it is a write
  logic [3:0]     r_mask;
  logic [WAW-1:0] r_widx;
  logic           r_rd_vld;
  logic [3:0]     r_fwd_mask;  // lanes of the read word taken from the colliding write
  logic [31:0]    r_fwd_dat;

  logic [31:0]    w_offset;
  logic [WAW-1:0] w_widx;
  logic           w_in_range;
  logic           w_misalign;
  logic           w_ro_err;
  logic           w_err;
  logic           w_accept;
  logic           w_commit;
  logic [31:0]    w_q;
  logic           w_unused;

  assign w_offset   = addr - BASE_ADDR;
  assign w_widx     = WAW'(w_offset >> 2);
  assign w_in_range = w_offset < 32'(MEM_BYTES);
  assign w_misalign = ((size == SIZE_HALF) && addr[0]) ||
                      ((size == SIZE_WORD) && (addr[1:0] != 2'b00));

`ifdef SRAM_RO_REGION_EN
  assign w_ro_err = write && (w_offset < 32'(RO_BYTES));
`else
  assign w_ro_err = 1'b0;
`endif

  assign w_err = !w_in_range || (size > SIZE_WORD) || w_misalign || w_ro_err;

  // Only IDLE and ERR2 drive ready_out high, so a new address phase is taken
  // only there; the guard also ignores a bus that ignores our wait states.
  assign w_accept = sel && ready && ((trans == TRANS_NONSEQ) || (trans == TRANS_SEQ)) &&
                    ((r_state == S_IDLE) || (r_state == S_ERR2));

  // A pending good write completes on the edge where IDLE drives ready_out high.
  assign w_commit = (r_state == S_IDLE) && r_pend && r_wr;

  assign ready_out = (r_state == S_IDLE) || (r_state == S_ERR2);
  assign resp      = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? RESP_ERROR : RESP_OKAY;

  assign w_unused = ^{burst, prot, mastlock, (RO_BYTES != 0)};

  sram_byte_array #(
    .WORDS (WORDS),
    .AW    (WAW)
  ) u_array (
    .i_clk   (clock),
    .i_re    (w_accept && !w_err && !write),
    .i_raddr (w_widx),
    .o_rdata (w_q),
    .i_we    (w_commit),
    .i_waddr (r_widx),
    .i_be    (r_mask),
    .i_wdata (wdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE, S_ERR2: begin
          if (w_accept && w_err) begin
            r_state <= S_ERR1;
          end else if (w_accept && (WAIT_STATES > 0)) begin
            r_state <= S_WAIT;
            r_cnt   <= LP_WS_LOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ERR1:  r_state <= S_ERR2;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend     <= 1'b0;
      r_wr       <= 1'b0;
      r_mask     <= 4'b0000;
      r_widx     <= '0;
      r_rd_vld   <= 1'b0;
      r_fwd_mask <= 4'b0000;
      r_fwd_dat  <= 32'd0;
    end else if (w_accept) begin
      r_pend     <= !w_err;
      r_wr       <= write && !w_err;
      r_mask     <= lane_mask(size, addr[1:0]);
      r_widx     <= w_widx;
      r_rd_vld   <= !w_err && !write;
      // The array returns the pre-write word when a read collides with the
      // completing write, so remember which lanes to patch from wdata.
      r_fwd_mask <= (w_commit && (r_widx == w_widx)) ? r_mask : 4'b0000;
      r_fwd_dat  <= wdata;
    end else if (r_state == S_IDLE) begin
      r_pend <= 1'b0;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (r_rd_vld) begin
      for (int i = 0; i < 4; i++) begin
        rdata[8*i +: 8] = r_fwd_mask[i] ? r_fwd_dat[8*i +: 8] : w_q[8*i +: 8];
      end
    end
  end

endmodule
